// File: rtl/hex8_scan_ctrl.sv
// hex8_scan_ctrl: time-multiplexed scan controller for an 8-digit
// seven-segment display. A 32-bit hex value, 8 decimal points and 8 blank
// flags are double-buffered: loads land in a shadow register and are
// committed to the display register only at frame boundaries, so a frame
// is never torn. A load that coincides with the boundary bypasses the
// shadow and becomes visible on the very next cycle.
module hex8_scan_ctrl #(
  parameter int unsigned DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] din,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  seg_cs_pin,
  output logic [7:0]  seg_data_0_pin,
  output logic [7:0]  seg_data_1_pin
);

  localparam int unsigned          CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DIV - 1);

  // Hex nibble to {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Packed display word layout: {value[31:0], dp[7:0], blank[7:0]}.
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       idx_q,     idx_d;
  logic [47:0]      shadow_q,  shadow_d;
  logic [47:0]      disp_q,    disp_d;
  logic             pending_q, pending_d;
  logic             ftick_q,   ftick_d;
  logic [7:0]       cs_q,      cs_d;
  logic [7:0]       seg0_q,    seg0_d;
  logic [7:0]       seg1_q,    seg1_d;

  logic             wrap_s;
  logic             boundary_s;
  logic [47:0]      load_word_s;
  logic [31:0]      disp_val_s;
  logic [7:0]       disp_dp_s;
  logic [7:0]       disp_blank_s;
  logic [3:0]       nib_s;
  logic [7:0]       seg_s;

  // Next-state: scan counter, double-buffer commit and registered outputs.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    ftick_d      = 1'b0;
    cs_d         = 8'h00;
    seg0_d       = 8'h00;
    seg1_d       = 8'h00;

    wrap_s       = (cnt_q == CNT_MAX);
    boundary_s   = wrap_s && (idx_q == 3'd7);
    load_word_s  = {din, dp_in, blank_in};

    if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end

    ftick_d = boundary_s;

    // A load on the boundary edge goes straight to the display; otherwise
    // it waits in the shadow until the next boundary.
    if (load && boundary_s) begin
      disp_d    = load_word_s;
      shadow_d  = load_word_s;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = load_word_s;
      pending_d = 1'b1;
    end else if (boundary_s && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    // Outputs are decoded from the current idx/display and registered,
    // so they trail idx by one cycle.
    disp_val_s   = disp_q[47:16];
    disp_dp_s    = disp_q[15:8];
    disp_blank_s = disp_q[7:0];
    nib_s        = disp_val_s[{idx_q, 2'b00} +: 4];
    if (disp_blank_s[idx_q]) begin
      seg_s = 8'h00;
    end else begin
      seg_s = {disp_dp_s[idx_q], hex_to_seg(nib_s)};
    end

    if (en) begin
      cs_d = 8'h01 << idx_q;
      if (idx_q[2]) begin
        seg0_d = 8'h00;
        seg1_d = seg_s;
      end else begin
        seg0_d = seg_s;
        seg1_d = 8'h00;
      end
    end else begin
      cs_d   = 8'h00;
      seg0_d = 8'h00;
      seg1_d = 8'h00;
    end
  end

  // State and output registers with synchronous reset that overrides load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= 3'd0;
      shadow_q  <= 48'h0;
      disp_q    <= 48'h0;
      pending_q <= 1'b0;
      ftick_q   <= 1'b0;
      cs_q      <= 8'h00;
      seg0_q    <= 8'h00;
      seg1_q    <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      ftick_q   <= ftick_d;
      cs_q      <= cs_d;
      seg0_q    <= seg0_d;
      seg1_q    <= seg1_d;
    end
  end

  assign pending        = pending_q;
  assign frame_tick     = ftick_q;
  assign seg_cs_pin     = cs_q;
  assign seg_data_0_pin = seg0_q;
  assign seg_data_1_pin = seg1_q;

endmodule

// File: tb/tb_hex8_scan_ctrl.sv
// Bench for hex8_scan_ctrl with DIV=4. A behavioural model tracks cycles
// since reset with plain arithmetic (digit = cycle/4 mod 8, boundary when
// cycle mod 32 = 31) and compares every output after every clock edge.
module tb_hex8_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] din = 32'h0;
  logic [7:0]  dp_in = 8'h00;
  logic [7:0]  blank_in = 8'h00;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  seg_cs_pin;
  logic [7:0]  seg_data_0_pin;
  logic [7:0]  seg_data_1_pin;

  hex8_scan_ctrl #(.DIV(DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .load           (load),
    .din            (din),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .pending        (pending),
    .frame_tick     (frame_tick),
    .seg_cs_pin     (seg_cs_pin),
    .seg_data_0_pin (seg_data_0_pin),
    .seg_data_1_pin (seg_data_1_pin)
  );

  always #5 clk = ~clk;

  // Seven-segment glyphs {g..a} for 0..F.
  logic [6:0] hex_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int chk_cnt = 0;
  int err_cnt = 0;

  // Model state.
  int          m_cyc     = 0;
  logic [31:0] m_sh_val  = 32'h0;
  logic [7:0]  m_sh_dp   = 8'h00;
  logic [7:0]  m_sh_bl   = 8'h00;
  logic [31:0] m_dv_val  = 32'h0;
  logic [7:0]  m_dv_dp   = 8'h00;
  logic [7:0]  m_dv_bl   = 8'h00;
  logic        m_pending = 1'b0;
  logic        m_ftick   = 1'b0;
  logic [7:0]  m_cs      = 8'h00;
  logic [7:0]  m_s0      = 8'h00;
  logic [7:0]  m_s1      = 8'h00;
  logic        cur_en    = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    int         idx;
    logic       bnd;
    logic [7:0] seg;
    rst = r; en = e; load = l; din = d; dp_in = dp; blank_in = bl;
    @(posedge clk);
    if (r) begin
      m_cyc = 0;
      m_sh_val = 32'h0; m_sh_dp = 8'h00; m_sh_bl = 8'h00;
      m_dv_val = 32'h0; m_dv_dp = 8'h00; m_dv_bl = 8'h00;
      m_pending = 1'b0; m_ftick = 1'b0;
      m_cs = 8'h00; m_s0 = 8'h00; m_s1 = 8'h00;
    end else begin
      idx = (m_cyc / DIV) % 8;
      bnd = ((m_cyc % FRAME) == FRAME - 1);
      if (m_dv_bl[idx]) seg = 8'h00;
      else              seg = {m_dv_dp[idx], hex_tab[m_dv_val[4*idx +: 4]]};
      m_cs    = e ? (8'h01 << idx) : 8'h00;
      m_s0    = (e && idx < 4)  ? seg : 8'h00;
      m_s1    = (e && idx >= 4) ? seg : 8'h00;
      m_ftick = bnd;
      if (l && bnd) begin
        m_dv_val = d; m_dv_dp = dp; m_dv_bl = bl;
        m_sh_val = d; m_sh_dp = dp; m_sh_bl = bl;
        m_pending = 1'b0;
      end else if (l) begin
        m_sh_val = d; m_sh_dp = dp; m_sh_bl = bl;
        m_pending = 1'b1;
      end else if (bnd && m_pending) begin
        m_dv_val = m_sh_val; m_dv_dp = m_sh_dp; m_dv_bl = m_sh_bl;
        m_pending = 1'b0;
      end
      m_cyc++;
    end
    #1;
    check_eq("pending",    {31'h0, pending},        {31'h0, m_pending});
    check_eq("frame_tick", {31'h0, frame_tick},     {31'h0, m_ftick});
    check_eq("seg_cs",     {24'h0, seg_cs_pin},     {24'h0, m_cs});
    check_eq("seg_data_0", {24'h0, seg_data_0_pin}, {24'h0, m_s0});
    check_eq("seg_data_1", {24'h0, seg_data_1_pin}, {24'h0, m_s1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_en, 1'b0, 32'h0, 8'h00, 8'h00);
  endtask

  // Idle until the next edge is the given in-frame position (0..31).
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != pos; i++) idle(1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    step(1'b0, cur_en, 1'b1, d, dp, bl);
  endtask

  initial begin
    // Reset and free-running scan with nothing loaded.
    step(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 8'h00);
    idle(40);

    // Mid-frame load, committed at the next boundary.
    run_to(10);
    do_load(32'h89ABCDEF, 8'h00, 8'h00);
    idle(70);

    // Load exactly on the boundary edge: bypass, one-cycle latency.
    run_to(FRAME - 1);
    do_load(32'h00000001, 8'h00, 8'h00);
    idle(40);

    // Two loads in one frame: last one wins.
    run_to(5);
    do_load(32'h11111111, 8'h00, 8'h00);
    run_to(20);
    do_load(32'h22222222, 8'h00, 8'h00);
    idle(70);

    // Decimal point on digit 0, blank on digit 7.
    run_to(3);
    do_load(32'h00000000, 8'h01, 8'h80);
    idle(70);

    // Display disabled, reset pulsed while a load is pending.
    run_to(8);
    cur_en = 1'b0;
    idle(3);
    do_load(32'h76543210, 8'hF0, 8'h00);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 8'h00);
    idle(3);
    cur_en = 1'b1;
    idle(80);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        r, e, l;
      logic [31:0] d;
      logic [7:0]  dp, bl;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 7) != 0);
      l  = ($urandom_range(0, 9) == 0);
      d  = $urandom;
      dp = 8'($urandom);
      bl = 8'($urandom) & 8'($urandom);
      step(r, e, l, d, dp, bl);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
